// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared channel-select type, channel count and select decode
//                for the registered 1:4 demultiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package demux_pkg;

    typedef logic [1:0] chan_sel_t;

    localparam int NUM_CHAN = 4;

    function automatic logic [NUM_CHAN-1:0] sel_onehot(input chan_sel_t sel);
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry holding register for a single output channel with
//                valid/ready handshake; load wins over a same-cycle drain.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             free
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    // Slot can take a word if empty or being emptied this cycle.
    assign free      = ~r_valid | out_ready;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux1_4_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_4_reg
//  Description : Registered 1-to-4 demultiplexer; steers each accepted word to
//                the channel chosen by in_sel, one holding slot per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module demux1_4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [1:0]                     in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_CHAN-1:0][WIDTH-1:0] out_data,
    output logic [NUM_CHAN-1:0]            out_valid,
    input  logic [NUM_CHAN-1:0]            out_ready
);

    logic [NUM_CHAN-1:0] w_free;
    logic [NUM_CHAN-1:0] w_load;
    logic                w_acc;

    // Readiness follows only the addressed slot, so a stalled channel blocks
    // the input only while it is selected.
    assign in_ready = w_free[in_sel];
    assign w_acc    = in_valid & in_ready;
    assign w_load   = w_acc ? sel_onehot(chan_sel_t'(in_sel)) : '0;

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_slot
            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .load      (w_load[gi]),
                .load_data (in_data),
                .out_ready (out_ready[gi]),
                .out_data  (out_data[gi]),
                .out_valid (out_valid[gi]),
                .free      (w_free[gi])
            );
        end
    endgenerate

endmodule : demux1_4_reg
`default_nettype wire

// File: doc/demux1_4_reg.md
# demux1_4_reg

Registered 1-to-4 demultiplexer with a valid/ready handshake on the input and on each output. It steers one input word to one of four output channels chosen by a 2-bit select, so it performs the inverse of the 4:1 select path. Each channel holds its word in a one-entry register until the consumer accepts it. It is used in the datapath wherever one producer feeds one of four consumers, such as register-bank write steering and per-unit result routing.

## Interface
- WIDTH, 64, data width of the input and of each output channel
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination channel index, 0..3
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the input this cycle
- out_data  output  4×WIDTH  per-channel held word, channel i = out_data[i]
- out_valid  output  4  per-channel word present
- out_ready  input  4  per-channel consumer accepts

## Operation
- Each channel i has two registers: slot_data[i] (WIDTH bits) and slot_valid[i] (1 bit). out_data[i] = slot_data[i] and out_valid[i] = slot_valid[i], both driven directly from the registers.
- Input transfer (acc) = in_valid & in_ready.
- in_ready = ~slot_valid[in_sel] | out_ready[in_sel]. It depends only on in_sel and the state and ready of the selected slot. It never depends on in_valid.
- Output transfer on channel i (drain_i) = slot_valid[i] & out_ready[i].
- Per-channel next state, evaluated in priority order:
  - reset: slot_valid[i] ← 0 and slot_data[i] ← 0.
  - acc & in_sel==i: slot_data[i] ← in_data and slot_valid[i] ← 1. This applies whether or not drain_i occurs in the same cycle (simultaneous drain and refill).
  - drain_i: slot_valid[i] ← 0. slot_data[i] holds its value.
  - otherwise: both registers hold.
- Per cycle, at most one channel loads and any subset of channels drains.
- Non-selected channels are unaffected by the input.
- A stall on one channel blocks the input only while in_sel points at that channel. Other destinations proceed.
- While out_valid[i]=1 and out_ready[i]=0, out_data[i] stays stable.
- in_sel values are all legal. There is no out-of-range case.
- No data is dropped or duplicated. Each accepted word appears exactly once on its selected channel.

## Timing
- Reset values: out_valid = 4'b0000, out_data = all zeros. in_ready = 1 after reset, because all slots are empty.
- Reset asserted mid-operation clears every slot at that edge, regardless of in_valid or out_ready in that cycle. Words held at that point are discarded.
- Latency is one cycle. A word accepted at edge N is visible on out_data[in_sel] with out_valid high from edge N onward, so the consumer can take it in cycle N+1.
- Throughput is one word per cycle, including back-to-back words to the same channel, provided that channel's out_ready is high.
- Combinational paths: out_ready → in_ready, and in_sel → in_ready. There is no path from any input to out_data or out_valid.
- Stability rule: in_data and in_sel must be held stable while in_valid=1 and in_ready=0. The block does not check this.

## Structure
- Shared package demux_pkg contains:
  - typedef chan_sel_t = logic [1:0]
  - localparam NUM_CHAN = 4
- Sub-module demux_slot: one channel's holding register. Parameter WIDTH.
  - Ports: clk, reset, load, load_data, out_ready, out_data, out_valid, free.
  - free = ~out_valid | out_ready.
- Top level instantiates four demux_slot instances with a generate loop. It decodes in_sel to a one-hot load vector gated by acc, and selects in_ready from the four free signals by in_sel.

## Test plan
- Reset then idle: assert reset for 2 cycles with in_valid=1 → out_valid=0000, out_data all 0, in_ready=1 after reset releases.
- Route to each channel: out_ready=0000; send 0xA0,0xA1,0xA2,0xA3 with in_sel 0,1,2,3 → out_valid=1111 after the 4th edge and out_data[i]=0xA0+i. A 5th word to sel=2 sees in_ready=0 and is not accepted.
- Stall isolation: channel 1 full with out_ready[1]=0; send 0x55 to sel=3 → accepted in 1 cycle, out_data[3]=0x55, out_data[1] unchanged.
- Simultaneous drain and refill: channel 0 holds 0x11, out_ready[0]=1, input 0x22 with sel=0 → in_ready=1, out_valid[0] stays 1, out_data[0]=0x22 next cycle, and the consumer saw 0x11 exactly once.
- Streaming: 100 random words with random sel, out_ready random at 50% → scoreboard per channel shows in-order, no loss, no duplicates. out_data is stable while valid and not ready.
- Reset mid-operation: all four channels full, assert reset for one cycle with in_valid=1, sel=2 → out_valid=0000 the next cycle and the input word is not captured.
